// File: rtl/qpp_interleaver_if.sv
// Handshake and data bundle between the block source, the QPP interleaver
// and the two RSC constituent encoders it feeds.
interface qpp_interleaver_if;
  logic din;
  logic din_valid;
  logic K;
  logic in_ready;
  logic data_ready;
  logic ck_nat;
  logic ck_int;
  logic busy;
  logic blk_done;

  modport master (
    output din, din_valid, K,
    input  in_ready, data_ready, ck_nat, ck_int, busy, blk_done
  );

  modport slave (
    input  din, din_valid, K,
    output in_ready, data_ready, ck_nat, ck_int, busy, blk_done
  );
endinterface

// File: rtl/qpp_interleaver.sv
// LTE turbo-code QPP interleaver: buffers one code block, then replays it in
// natural and QPP-permuted order to the two constituent encoders.
module qpp_interleaver #(
  parameter int MAX_K    = 6144,
  parameter int TAIL_GAP = 4
) (
  input logic               clk,
  input logic               aclr,
  qpp_interleaver_if.slave  bus
);

  localparam int IW = $clog2(MAX_K);
  localparam int TW = $clog2(TAIL_GAP + 1);

  localparam logic [IW-1:0] K_S      = IW'(1056);
  localparam logic [IW-1:0] K_L      = IW'(6144);
  localparam logic [IW-1:0] G_INIT_S = IW'((17 + 66) % 1056);
  localparam logic [IW-1:0] G_INIT_L = IW'((263 + 480) % 6144);
  localparam logic [IW-1:0] TWO_F2_S = IW'((2 * 66) % 1056);
  localparam logic [IW-1:0] TWO_F2_L = IW'((2 * 480) % 6144);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, TAIL} state_t;

  state_t        state;
  logic          ksel;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] pi;
  logic [IW-1:0] g;
  logic [TW-1:0] tail_cnt;
  logic          mem [MAX_K];

  logic [IW-1:0] k_len, k_last, g_init, two_f2;
  logic [IW:0]   pi_sum, g_sum;
  logic [IW-1:0] pi_next, g_next;
  logic          wr_en;
  logic [IW-1:0] wr_addr;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    k_len  = K_S;
    g_init = G_INIT_S;
    two_f2 = TWO_F2_S;
    if (ksel) begin
      k_len  = K_L;
      g_init = G_INIT_L;
      two_f2 = TWO_F2_L;
    end
  end

  assign k_last = k_len - IW'(1);

  // Both addends are below K, so one conditional subtract completes the mod.
  assign pi_sum  = {1'b0, pi} + {1'b0, g};
  assign g_sum   = {1'b0, g} + {1'b0, two_f2};
  assign pi_next = (pi_sum >= {1'b0, k_len}) ? IW'(pi_sum - {1'b0, k_len}) : pi_sum[IW-1:0];
  assign g_next  = (g_sum  >= {1'b0, k_len}) ? IW'(g_sum  - {1'b0, k_len}) : g_sum[IW-1:0];

  assign wr_en   = bus.din_valid && (state == IDLE || state == LOAD);
  assign wr_addr = (state == IDLE) ? '0 : wr_idx;

  // NOTE: the block buffer has no reset; its contents are always rewritten
  // before they are read, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= bus.din;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state          <= IDLE;
      ksel           <= 1'b0;
      wr_idx         <= '0;
      rd_idx         <= '0;
      pi             <= '0;
      g              <= '0;
      tail_cnt       <= '0;
      bus.in_ready   <= 1'b1;
      bus.data_ready <= 1'b0;
      bus.ck_nat     <= 1'b0;
      bus.ck_int     <= 1'b0;
      bus.busy       <= 1'b0;
      bus.blk_done   <= 1'b0;
    end else begin
      bus.data_ready <= 1'b0;
      bus.blk_done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.din_valid) begin
            ksel     <= bus.K;
            wr_idx   <= IW'(1);
            bus.busy <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (bus.din_valid) begin
            if (wr_idx == k_last) begin
              // Present bit 0 on both outputs right away: zero-cycle turnaround.
              state          <= DRAIN;
              bus.in_ready   <= 1'b0;
              rd_idx         <= '0;
              pi             <= '0;
              g              <= g_init;
              bus.data_ready <= 1'b1;
              bus.ck_nat     <= mem[0];
              bus.ck_int     <= mem[0];
            end else begin
              wr_idx <= wr_idx + IW'(1);
            end
          end
        end
        DRAIN: begin
          if (rd_idx == k_last) begin
            state        <= TAIL;
            bus.ck_nat   <= 1'b0;
            bus.ck_int   <= 1'b0;
            tail_cnt     <= '0;
            bus.blk_done <= (TAIL_GAP == 1);
          end else begin
            rd_idx     <= rd_idx + IW'(1);
            pi         <= pi_next;
            g          <= g_next;
            bus.ck_nat <= mem[rd_idx + IW'(1)];
            bus.ck_int <= mem[pi_next];
          end
        end
        TAIL: begin
          if (tail_cnt == TW'(TAIL_GAP - 1)) begin
            state        <= IDLE;
            bus.in_ready <= 1'b1;
            bus.busy     <= 1'b0;
            tail_cnt     <= '0;
          end else begin
            tail_cnt     <= tail_cnt + TW'(1);
            bus.blk_done <= (tail_cnt == TW'(TAIL_GAP - 2));
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qpp_interleaver.sv
// Directed bench for qpp_interleaver: full-block drains in both sizes against a
// closed-form QPP model, plus stalls, ignored input, mid-drain reset, back-to-back.
module tb_qpp_interleaver;

  localparam int TAIL_GAP = 4;

  logic clk = 1'b0;
  logic aclr;

  qpp_interleaver_if bus ();

  qpp_interleaver #(.MAX_K(6144), .TAIL_GAP(TAIL_GAP)) dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  bit blk_bits [6144];

  int obs_dr_cyc, obs_last_cyc, obs_nat_one, obs_int_one, obs_int_ones;
  int d1, d2, l1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Closed-form permutation, independent of the recursive hardware form.
  function automatic int pi_ref(input int i, input bit ksel);
    longint kk = ksel ? 6144 : 1056;
    longint f1 = ksel ? 263 : 17;
    longint f2 = ksel ? 480 : 66;
    longint li = i;
    return int'((f1 * li + f2 * li * li) % kk);
  endfunction

  // pat: 0 alternating, 1 one-hot at 743, 2 one-hot at 2446, 3 random.
  task automatic do_block(input bit ksel, input int pat, input bit stall,
                          input bit noise, input int abort_at);
    int kk = ksel ? 6144 : 1056;
    int i, j, n;
    for (int b = 0; b < kk; b++) begin
      case (pat)
        0:       blk_bits[b] = (b % 2 == 1);
        1:       blk_bits[b] = (b == 743);
        2:       blk_bits[b] = (b == 2446);
        default: blk_bits[b] = 1'($urandom);
      endcase
    end
    obs_dr_cyc = -1; obs_last_cyc = -1;
    obs_nat_one = -1; obs_int_one = -1; obs_int_ones = 0;

    @(negedge clk);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 32) begin
      @(negedge clk);
      n++;
    end
    check("idle_in_ready", bus.in_ready, 1'b1);
    check("idle_busy", bus.busy, 1'b0);
    if (bus.in_ready !== 1'b1) return;

    i = 0; j = 0;
    while (i < kk) begin
      if (j > 0) @(negedge clk);
      if (stall && (j % 2 == 1)) begin
        bus.din_valid = 1'b0;
        bus.din       = 1'($urandom);
      end else begin
        bus.din_valid = 1'b1;
        bus.din       = blk_bits[i];
      end
      bus.K = (i == 0) ? ksel : 1'($urandom);
      @(posedge clk);
      if (bus.din_valid) i++;
      j++;
    end

    for (int c = 0; c < kk; c++) begin
      @(negedge clk);
      if (c == 0) obs_dr_cyc = cyc;
      check($sformatf("data_ready[%0d]", c), bus.data_ready, (c == 0));
      check($sformatf("ck_nat[%0d]", c), bus.ck_nat, blk_bits[c]);
      check($sformatf("ck_int[%0d]", c), bus.ck_int, blk_bits[pi_ref(c, ksel)]);
      if (c == 0 || c == kk - 1) begin
        check($sformatf("drain_in_ready[%0d]", c), bus.in_ready, 1'b0);
        check($sformatf("drain_busy[%0d]", c), bus.busy, 1'b1);
      end
      if (bus.ck_nat === 1'b1 && obs_nat_one < 0) obs_nat_one = c;
      if (bus.ck_int === 1'b1) begin
        obs_int_ones++;
        if (obs_int_one < 0) obs_int_one = c;
      end
      if (c == abort_at) begin
        aclr = 1'b1;
        bus.din_valid = 1'b0;
        #1;
        check("abort_data_ready", bus.data_ready, 1'b0);
        check("abort_ck_nat", bus.ck_nat, 1'b0);
        check("abort_ck_int", bus.ck_int, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_blk_done", bus.blk_done, 1'b0);
        check("abort_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        aclr = 1'b0;
        for (int t = 0; t < 8; t++) begin
          @(negedge clk);
          check($sformatf("post_abort_blk_done[%0d]", t), bus.blk_done, 1'b0);
          check($sformatf("post_abort_data_ready[%0d]", t), bus.data_ready, 1'b0);
        end
        return;
      end
      obs_last_cyc  = cyc;
      bus.din_valid = noise;
      bus.din       = 1'($urandom);
      bus.K         = 1'($urandom);
    end

    for (int t = 0; t < TAIL_GAP; t++) begin
      @(negedge clk);
      check($sformatf("tail_ck_nat[%0d]", t), bus.ck_nat, 1'b0);
      check($sformatf("tail_ck_int[%0d]", t), bus.ck_int, 1'b0);
      check($sformatf("tail_blk_done[%0d]", t), bus.blk_done, (t == TAIL_GAP - 1));
      check($sformatf("tail_data_ready[%0d]", t), bus.data_ready, 1'b0);
      check($sformatf("tail_in_ready[%0d]", t), bus.in_ready, 1'b0);
      check($sformatf("tail_busy[%0d]", t), bus.busy, 1'b1);
      bus.din_valid = noise && (t < TAIL_GAP - 1);
      bus.din       = 1'($urandom);
      bus.K         = 1'($urandom);
    end
    bus.din_valid = 1'b0;
  endtask

  initial begin
    aclr          = 1'b1;
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    bus.K         = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_data_ready", bus.data_ready, 1'b0);
    check("rst_ck_nat", bus.ck_nat, 1'b0);
    check("rst_ck_int", bus.ck_int, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_blk_done", bus.blk_done, 1'b0);
    aclr = 1'b0;

    // 1: K=1056 alternating block; PI(1)=83 is odd, so ck_int also alternates.
    do_block(1'b0, 0, 1'b0, 1'b0, -1);
    check("t1_nat_first_one", obs_nat_one, 1);
    check("t1_int_first_one", obs_int_one, 1);
    check("t1_int_ones", obs_int_ones, 528);

    // 2: K=6144 one-hot at 743, PI(1)=743; then one-hot at 2446, PI(2)=2446.
    do_block(1'b1, 1, 1'b0, 1'b0, -1);
    check("t2_nat_first_one", obs_nat_one, 743);
    check("t2_int_first_one", obs_int_one, 1);
    check("t2_int_ones", obs_int_ones, 1);
    do_block(1'b1, 2, 1'b0, 1'b0, -1);
    check("t2b_int_first_one", obs_int_one, 2);
    check("t2b_int_ones", obs_int_ones, 1);

    // 3: same as test 1 with every other load cycle stalled.
    do_block(1'b0, 0, 1'b1, 1'b0, -1);
    check("t3_int_first_one", obs_int_one, 1);
    check("t3_int_ones", obs_int_ones, 528);

    // 4: din_valid held and K toggled throughout DRAIN and TAIL.
    do_block(1'b0, 3, 1'b0, 1'b1, -1);
    check("t4_drain_len", obs_last_cyc - obs_dr_cyc, 1055);

    // 5: reset in DRAIN cycle 500, then a clean block.
    do_block(1'b0, 3, 1'b0, 1'b0, 500);
    do_block(1'b0, 3, 1'b0, 1'b0, -1);
    check("t5_drain_len", obs_last_cyc - obs_dr_cyc, 1055);

    // 6: back-to-back K=1056 then K=6144 with no load stalls.
    do_block(1'b0, 3, 1'b0, 1'b0, -1);
    d1 = obs_dr_cyc;
    l1 = obs_last_cyc;
    do_block(1'b1, 3, 1'b0, 1'b0, -1);
    d2 = obs_dr_cyc;
    check("t6_first_drain_len", l1 - d1, 1055);
    check("t6_b2b_gap", d2 - l1, TAIL_GAP + 1 + 6144);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
